// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bundle: memory request/response plus the IF/ID boundary.
// Master is the fetch unit; slave is the memory/decode environment.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_fault;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_count;
`endif

    modport master (
        output imem_addr, if_instr, if_pc, if_valid, if_fault,
`ifdef FETCH_PERF_COUNT_EN
        output fetch_count,
`endif
        input  imem_instr, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, if_instr, if_pc, if_valid, if_fault,
`ifdef FETCH_PERF_COUNT_EN
        input  fetch_count,
`endif
        output imem_instr, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RISC-V fetch stage (optional FETCH_PERF_COUNT_EN adds fetch_count); owns the PC.
// Latency: address issued at edge N is presented after edge N+1.
// Backpressure: stall re-issues the held address; redirect overrides stall.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     bus
);
    localparam logic [31:0] LIMIT = 32'(IMEM_BYTES);

    typedef enum logic {RUN, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] target;
    logic        target_ok;
    logic        pc_ok;
    logic        if_valid;
    logic        unused_redirect_lsbs;

    assign target               = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign target_ok            = target < LIMIT;
    assign pc_ok                = pc_q < LIMIT;
    assign if_valid             = resp_valid_q & ~bus.redirect;

    // Re-issuing resp_pc during a stall keeps the memory output stable.
    assign bus.imem_addr = (state_q == RUN && bus.stall && !bus.redirect) ? resp_pc_q : pc_q;
    assign bus.if_instr  = bus.imem_instr;
    assign bus.if_pc     = resp_pc_q;
    assign bus.if_valid  = if_valid;
    assign bus.if_fault  = fault_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        fault_d      = fault_q;
        unique case (state_q)
            RUN: begin
                if (bus.redirect) begin
                    pc_d         = target;
                    resp_valid_d = 1'b0;
                    if (!target_ok) begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end else if (!bus.stall) begin
                    if (pc_ok) begin
                        resp_pc_d    = pc_q;
                        resp_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                    end else begin
                        resp_valid_d = 1'b0;
                        state_d      = HALT;
                        fault_d      = 1'b1;
                    end
                end
            end
            HALT: begin
                resp_valid_d = 1'b0;
                if (bus.redirect && target_ok) begin
                    pc_d    = target;
                    state_d = RUN;
                    fault_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] count_q, count_d;

    assign count_d         = (state_q == RUN && if_valid && !bus.stall) ? count_q + 32'd1 : count_q;
    assign bus.fetch_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) count_q <= 32'd0;
        else     count_q <= count_d;
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: program-order scoreboard fed by stimulus, monitor pops on accept.
module tb_instr_fetch_unit;
    localparam int          IMEM = 64;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(RPC), .IMEM_BYTES(IMEM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:63];

    always @(posedge clk)
        bus.imem_instr <= (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:2]] : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] exp_pc;
    int          total = 0;
    int          bad   = 0;
    int unsigned acc_count;
    logic [31:0] last_acc_pc;
    logic        prev_hold;
    logic [31:0] prev_pc, prev_instr;
    logic        seen;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic see(input string n, input logic [31:0] pc, input logic [31:0] ins);
        chk({n, "_valid"}, 32'(bus.if_valid), 32'd1);
        chk({n, "_pc"}, bus.if_pc, pc);
        chk({n, "_instr"}, bus.if_instr, ins);
    endtask

    // Reference: after reset or redirect, the accepted stream is target, target+4, ...
    // up to the last in-range word, each carrying mem[pc].
    task automatic refill();
        while (exp_q.size() < 2 && exp_pc < 32'(IMEM)) begin
            exp_q.push_back('{pc: exp_pc, instr: mem[exp_pc[7:2]]});
            exp_pc += 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic do_redirect(input logic [31:0] t);
        bus.redirect    = 1'b1;
        bus.redirect_pc = t;
        exp_q.delete();
        exp_pc = {t[31:2], 2'b00};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_pc = RPC;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            acc_count = 0;
        end else begin
            if (bus.redirect)
                chk("redirect_kill", 32'(bus.if_valid), 32'd0);
            if (prev_hold && !bus.redirect) begin
                chk("hold_valid", 32'(bus.if_valid), 32'd1);
                chk("hold_pc", bus.if_pc, prev_pc);
                chk("hold_instr", bus.if_instr, prev_instr);
            end
            if (bus.if_valid && !bus.stall) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_accept: got pc %h want no valid output", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_pc", bus.if_pc, e.pc);
                    chk("acc_instr", bus.if_instr, e.instr);
                end
                acc_count++;
                last_acc_pc = bus.if_pc;
            end
            prev_hold  = bus.if_valid && bus.stall && !bus.redirect;
            prev_pc    = bus.if_pc;
            prev_instr = bus.if_instr;
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0011_0533;
        mem[1] = 32'h4032_05B3;
        mem[2] = 32'h0011_4633;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        do_reset();
        repeat (2) step();
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_fault", 32'(bus.if_fault), 32'd0);
        chk("rst_pc", bus.if_pc, RPC);
        chk("rst_addr", bus.imem_addr, RPC);

        rst = 1'b0;
        #1;
        chk("boot_c1_valid", 32'(bus.if_valid), 32'd0);
        chk("boot_c1_addr", bus.imem_addr, RPC);
        step(); see("boot0", 32'h0, 32'h0011_0533);
        step(); see("boot1", 32'h4, 32'h4032_05B3);

        bus.stall = 1'b1;
        #1;     see("stall_a", 32'h4, 32'h4032_05B3);
        step(); see("stall_b", 32'h4, 32'h4032_05B3);
        step(); see("stall_c", 32'h4, 32'h4032_05B3);
        step(); bus.stall = 1'b0;
        #1;     see("stall_rel", 32'h4, 32'h4032_05B3);
        step(); see("after_stall", 32'h8, 32'h0011_4633);

        do_redirect(32'h0000_0022);
        #1;
        chk("redir_now", 32'(bus.if_valid), 32'd0);
        step(); bus.redirect = 1'b0;
        #1;
        chk("redir_next", 32'(bus.if_valid), 32'd0);
        step(); see("redir_tgt", 32'h20, mem[8]);

        bus.stall = 1'b1;
        do_redirect(32'h0);
        #1;
        chk("redir_stall_now", 32'(bus.if_valid), 32'd0);
        step(); bus.stall = 1'b0; bus.redirect = 1'b0;
        #1;
        chk("redir_stall_next", 32'(bus.if_valid), 32'd0);
        step(); see("redir_stall_tgt", 32'h0, 32'h0011_0533);

        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = bus.if_fault;
        end
        chk("fault_seen", 32'(seen), 32'd1);
        chk("last_valid_pc", last_acc_pc, 32'(IMEM - 4));
        repeat (3) begin
            step();
            chk("halt_valid", 32'(bus.if_valid), 32'd0);
            chk("halt_fault", 32'(bus.if_fault), 32'd1);
        end
        bus.stall = 1'b1;
        #1;
        chk("halt_addr_ignores_stall", bus.imem_addr, 32'(IMEM));
        bus.stall = 1'b0;

        do_redirect(32'h4);
        step(); bus.redirect = 1'b0;
        #1;
        chk("recover_fault", 32'(bus.if_fault), 32'd0);
        chk("recover_gap", 32'(bus.if_valid), 32'd0);
        step(); see("recover", 32'h4, mem[1]);

        for (int c = 0; c < 800; c++) begin
            step();
            bus.stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) do_redirect(32'($urandom_range(0, IMEM + 40)));
            else                            bus.redirect = 1'b0;
        end
        step();
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        #1;
`ifdef FETCH_PERF_COUNT_EN
        chk("perf_count", bus.fetch_count, acc_count);
`endif

        do_redirect(32'hC);
        step(); bus.redirect = 1'b0;
        step(); see("pre_reset", 32'hC, mem[3]);
        bus.stall = 1'b1;
        do_reset();
        step();
        chk("midrst_valid", 32'(bus.if_valid), 32'd0);
        chk("midrst_fault", 32'(bus.if_fault), 32'd0);
        chk("midrst_addr", bus.imem_addr, RPC);
        chk("midrst_pc", bus.if_pc, RPC);
`ifdef FETCH_PERF_COUNT_EN
        chk("midrst_count", bus.fetch_count, 32'd0);
`endif
        rst       = 1'b0;
        bus.stall = 1'b0;
        step(); see("post_reset", 32'h0, 32'h0011_0533);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the pipelined RISC-V core; the requesting (reader) side of the instruction memory interface.
- Owns the PC, presents byte addresses to the instruction memory and accounts for its one-cycle registered read latency.
- Delivers instruction, PC and valid to the IF/ID boundary.
- Handles decode stall, branch/jump redirect and out-of-range fetch halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_BYTES, 4096, size of the fetchable byte-address space. Legal fetch address range is 0..IMEM_BYTES-4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory. Memory returns mem[addr] one clock later.
- imem_instr  in  32  registered memory read data.
- stall  in  1  hold the fetch stage (load-use or decode backpressure).
- redirect  in  1  taken branch or jump; flush the fetch stage.
- redirect_pc  in  32  redirect target (byte address).
- if_instr  out  32  fetched instruction.
- if_pc  out  32  byte address of if_instr.
- if_valid  out  1  if_instr/if_pc are a real, non-flushed instruction.
- if_fault  out  1  sticky: fetch address out of range, fetch halted.

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Registers:
  - pc: next address to issue.
  - resp_pc: address issued last cycle.
  - resp_valid.
  - state: RUN or HALT.
  - fault.
- Reset (rst=1 at a rising edge; overrides all other inputs, including mid-stall and mid-redirect):
  - pc=RESET_PC, resp_pc=RESET_PC, resp_valid=0, state=RUN, fault=0.
  - Outputs during and right after reset: if_valid=0, if_fault=0, if_pc=RESET_PC, imem_addr=RESET_PC.
- Address mux (combinational):
  - imem_addr = resp_pc when stall=1 and redirect=0.
  - Otherwise imem_addr = pc.
  - Re-issuing resp_pc keeps imem_instr stable for the held instruction.
- Outputs (combinational):
  - if_instr = imem_instr.
  - if_pc = resp_pc.
  - if_valid = resp_valid & ~redirect.
  - if_fault = fault.
- Latency: address issued at edge N appears on if_instr after edge N+1. First valid instruction is 2 cycles after rst deasserts: cycle 1 issues RESET_PC, cycle 2 shows if_valid=1.
- Priority: rst > redirect > stall > normal advance.
- RUN state, redirect=1:
  - pc <= {redirect_pc[31:2],2'b00}. Low two bits are silently cleared.
  - resp_valid <= 0. The in-flight fetch is killed.
  - Output is wrong-path for that cycle (if_valid=0 combinationally).
- RUN state, stall=1, redirect=0: pc, resp_pc, resp_valid all hold.
- RUN state, normal advance:
  - resp_pc <= pc, resp_valid <= 1, pc <= pc+4.
  - 32-bit modular add; wrap is caught by the range check.
- Range check: when about to issue (advance, or redirect target) an address >= IMEM_BYTES:
  - that address is not marked valid;
  - state <= HALT, fault <= 1;
  - resp_valid <= 0 on the following cycle.
  - Instructions already issued in range still complete normally.
- HALT state:
  - pc holds, imem_addr = pc, resp_valid stays 0, stall is ignored.
  - Only a redirect to an in-range target returns to RUN: fault clears, pc loads the target.
  - A redirect to an out-of-range target keeps HALT.
- Stall and redirect in the same cycle: redirect wins and the stall is ignored.
- imem_instr is never checked for legality; decode owns illegal-opcode handling.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Defined:
  - Adds output port fetch_count (out, 32): count of cycles with if_valid=1 and stall=0 (instructions accepted by decode).
  - Reset to 0; wraps at 2^32; frozen in HALT.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Boot: memory preloaded mem[0]=32'h00110533, mem[4]=32'h403205B3, mem[8]=32'h00114633; release rst -> cycles 2,3,4 show if_valid=1 with (if_pc,if_instr) = (0,00110533), (4,403205B3), (8,00114633).
- Stall: assert stall for 3 cycles while if_pc=4 -> if_pc=4 and if_instr=32'h403205B3 held all 3 cycles with if_valid=1; after release, next is (8,00114633) with no skipped or duplicated PC.
- Redirect: redirect=1, redirect_pc=32'h0000_0022 while if_pc=8 -> if_valid=0 that cycle and the next; then if_pc=32'h20 with if_instr=mem[32].
- Redirect during stall: stall=1 and redirect=1 with redirect_pc=0 -> stall ignored; 2 cycles later if_pc=0, if_instr=32'h00110533.
- Range fault (IMEM_BYTES=16): run from 0 -> valid PCs 0,4,8,12 only; then if_fault=1 and if_valid=0 persistently. Redirect to 4 clears if_fault, and if_pc=4 appears 2 cycles later.
- Reset mid-run: assert rst while if_pc=12 and stall=1 -> next cycle if_valid=0, if_fault=0, imem_addr=RESET_PC. With FETCH_PERF_COUNT_EN defined, fetch_count=0.
